// File: rtl/pwm_cmp_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cmp_unit_pkg
// Description : Shared definitions for the compare/PWM stage that sits behind
//               the N-bit universal counter: count boundaries and the encoding
//               of the compare-update mode, plus the update-event helper.
// Contents    : CNT_W       default counter/compare width
//               MAX_COUNT   terminal count of the counter (2**CNT_W-1)
//               MIN_COUNT   bottom count of the counter (0)
//               UPD_EDGE    upd_mode value: update at min only
//               UPD_CENTER  upd_mode value: update at min or max
//               upd_event() period-boundary detector
// Revision    : 1.0  initial release
// ============================================================================
package pwm_cmp_unit_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] MAX_COUNT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_COUNT = '0;

  localparam logic UPD_EDGE   = 1'b0;
  localparam logic UPD_CENTER = 1'b1;

  // A period boundary is only real when the counter is actually stepping;
  // a paused counter sitting on min/max must not keep triggering transfers.
  function automatic logic upd_event(input logic en,
                                     input logic min_tick,
                                     input logic max_tick,
                                     input logic mode);
    return en & (min_tick | ((mode == UPD_CENTER) & max_tick));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_cmp_unit_cmp_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_shadow_reg
// Description : Double-buffered compare register. Software writes land in a
//               buffer at any time; the buffered value is moved into the
//               active compare register only at a period boundary so the PWM
//               output never changes shape mid-period.
// Ports       : clk         system clock, rising edge
//               n_reset     synchronous active-low reset
//               cnt_en      counter enable
//               max_tick    counter at MAX_COUNT
//               min_tick    counter at MIN_COUNT
//               upd_mode    UPD_EDGE / UPD_CENTER
//               cmp_wr      buffer write strobe
//               cmp_din     value to buffer
//               cmp_active  compare value currently in use
//               pending     buffer holds a value not yet transferred
// Revision    : 1.0  initial release
// ============================================================================
module cmp_shadow_reg
  import pwm_cmp_unit_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         cnt_en,
  input  logic         max_tick,
  input  logic         min_tick,
  input  logic         upd_mode,
  input  logic         cmp_wr,
  input  logic [N-1:0] cmp_din,
  output logic [N-1:0] cmp_active,
  output logic         pending
);

  logic [N-1:0] r_cmp_buf;
  logic [N-1:0] r_cmp_active;
  logic         r_pending;
  logic         w_upd_evt;

  assign w_upd_evt = upd_event(cnt_en, min_tick, max_tick, upd_mode);

  // On a write that collides with a boundary, the transfer uses the buffer
  // contents from before the write, and the new write stays pending for the
  // following boundary. Non-blocking semantics give exactly that ordering.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cmp_buf    <= '0;
      r_cmp_active <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (w_upd_evt && r_pending) begin
        r_cmp_active <= r_cmp_buf;
      end

      if (cmp_wr) begin
        r_cmp_buf <= cmp_din;
        r_pending <= 1'b1;
      end else if (w_upd_evt) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cmp_active = r_cmp_active;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: rtl/pwm_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cmp_unit
// Description : Compare/PWM stage fed by the N-bit universal counter. Compares
//               the counter value against a double-buffered compare value and
//               produces a registered PWM output, a one-cycle match strobe and
//               a sticky match interrupt with overrun detection.
// Ports       : clk         system clock, rising edge
//               n_reset     synchronous active-low reset
//               cnt_q       counter value
//               cnt_en      counter enable (same as the counter's en)
//               max_tick    counter at 2^N-1
//               min_tick    counter at 0
//               cmp_wr      compare buffer write strobe
//               cmp_din     compare value to buffer
//               upd_mode    0: update at min, 1: update at min or max
//               out_pol     0: active-high PWM, 1: inverted
//               irq_ack     clears irq and ovr
//               pwm_out     registered PWM
//               cmp_match   one-cycle match strobe
//               irq         sticky match interrupt
//               ovr         sticky overrun (match while irq already set)
//               cmp_active  compare value in use
//               pending     buffer holds an untransferred value
// Revision    : 1.0  initial release
// ============================================================================
module pwm_cmp_unit
  import pwm_cmp_unit_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] cnt_q,
  input  logic         cnt_en,
  input  logic         max_tick,
  input  logic         min_tick,
  input  logic         cmp_wr,
  input  logic [N-1:0] cmp_din,
  input  logic         upd_mode,
  input  logic         out_pol,
  input  logic         irq_ack,
  output logic         pwm_out,
  output logic         cmp_match,
  output logic         irq,
  output logic         ovr,
  output logic [N-1:0] cmp_active,
  output logic         pending
);

  logic [N-1:0] w_cmp_active;
  logic         w_hit;
  logic         w_below;

  logic         r_pwm;
  logic         r_match;
  logic         r_irq;
  logic         r_ovr;

  cmp_shadow_reg #(
    .N (N)
  ) u_shadow (
    .clk        (clk),
    .n_reset    (n_reset),
    .cnt_en     (cnt_en),
    .max_tick   (max_tick),
    .min_tick   (min_tick),
    .upd_mode   (upd_mode),
    .cmp_wr     (cmp_wr),
    .cmp_din    (cmp_din),
    .cmp_active (w_cmp_active),
    .pending    (pending)
  );

  // The compare always sees the active value from before any same-edge
  // transfer. Gating with cnt_en keeps a paused counter from re-firing.
  assign w_hit   = cnt_en & (cnt_q == w_cmp_active);

  // Level comparison: works unchanged for up and down counting. A compare
  // value of 0 gives 0% duty; 2^N-1 leaves only the top count inactive.
  assign w_below = (cnt_q < w_cmp_active);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_pwm   <= 1'b0;
      r_match <= 1'b0;
      r_irq   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_pwm   <= w_below ^ out_pol;
      r_match <= w_hit;

      // A new match always wins over an acknowledge in the same cycle so
      // that no event can be silently dropped.
      if (w_hit) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end

      // Overrun: a match arrives while the previous one is still flagged.
      if (w_hit && r_irq) begin
        r_ovr <= 1'b1;
      end else if (irq_ack) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign pwm_out    = r_pwm;
  assign cmp_match  = r_match;
  assign irq        = r_irq;
  assign ovr        = r_ovr;
  assign cmp_active = w_cmp_active;

endmodule

`default_nettype wire

// File: tb/tb_pwm_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_cmp_unit
// Description : Self-checking bench for pwm_cmp_unit (N=4). Counter values and
//               boundary ticks are driven directly; expected outputs come from
//               a behavioural model and are queued per cycle, then compared
//               after the clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_cmp_unit;

  localparam int W = 4;

  logic         clk;
  logic         n_reset;
  logic [W-1:0] cnt_q;
  logic         cnt_en;
  logic         max_tick;
  logic         min_tick;
  logic         cmp_wr;
  logic [W-1:0] cmp_din;
  logic         upd_mode;
  logic         out_pol;
  logic         irq_ack;
  logic         pwm_out;
  logic         cmp_match;
  logic         irq;
  logic         ovr;
  logic [W-1:0] cmp_active;
  logic         pending;

  pwm_cmp_unit #(.N(W)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .cnt_q      (cnt_q),
    .cnt_en     (cnt_en),
    .max_tick   (max_tick),
    .min_tick   (min_tick),
    .cmp_wr     (cmp_wr),
    .cmp_din    (cmp_din),
    .upd_mode   (upd_mode),
    .out_pol    (out_pol),
    .irq_ack    (irq_ack),
    .pwm_out    (pwm_out),
    .cmp_match  (cmp_match),
    .irq        (irq),
    .ovr        (ovr),
    .cmp_active (cmp_active),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         pwm;
    logic         match;
    logic         irq;
    logic         ovr;
    logic         pending;
    logic [W-1:0] active;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference state
  logic [W-1:0] m_buf    = '0;
  logic [W-1:0] m_active = '0;
  logic         m_pend   = 1'b0;
  logic         m_irq    = 1'b0;
  logic         m_ovr    = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive counter inputs, queue the model's prediction, clock,
  // then pop and compare. cmp_wr and irq_ack are one-shot.
  task automatic step(input logic [W-1:0] q, input logic en);
    exp_t e;
    logic hit;
    logic upd;
    cnt_q    = q;
    cnt_en   = en;
    min_tick = (q == 4'd0);
    max_tick = (q == 4'd15);
    hit = en & (q == m_active);
    upd = en & (min_tick | (upd_mode & max_tick));
    if (!n_reset) begin
      m_buf = '0; m_active = '0; m_pend = 1'b0; m_irq = 1'b0; m_ovr = 1'b0;
      e = '0;
    end else begin
      e.pwm   = (q < m_active) ^ out_pol;
      e.match = hit;
      m_ovr   = (hit && m_irq) ? 1'b1 : (irq_ack ? 1'b0 : m_ovr);
      m_irq   = hit ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
      if (upd && m_pend) m_active = m_buf;
      if (cmp_wr) begin
        m_buf  = cmp_din;
        m_pend = 1'b1;
      end else if (upd) begin
        m_pend = 1'b0;
      end
      e.irq = m_irq;
      e.ovr = m_ovr;
      e.pending = m_pend;
      e.active  = m_active;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmp_wr  = 1'b0;
    irq_ack = 1'b0;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 4'd1, 4'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pwm_out",    {3'b0, pwm_out},   {3'b0, e.pwm});
      chk("cmp_match",  {3'b0, cmp_match}, {3'b0, e.match});
      chk("irq",        {3'b0, irq},       {3'b0, e.irq});
      chk("ovr",        {3'b0, ovr},       {3'b0, e.ovr});
      chk("pending",    {3'b0, pending},   {3'b0, e.pending});
      chk("cmp_active", cmp_active,        e.active);
    end
  endtask

  initial begin
    n_reset = 1'b0; cnt_q = '0; cnt_en = 1'b0; max_tick = 1'b0; min_tick = 1'b0;
    cmp_wr = 1'b1; cmp_din = 4'd9; upd_mode = 1'b0; out_pol = 1'b0; irq_ack = 1'b0;
    @(posedge clk); #1;

    // Reset held over two edges with a write present
    cmp_wr = 1'b1; step(4'd3, 1'b1);
    cmp_wr = 1'b1; step(4'd3, 1'b1);
    chk("rst_active", cmp_active, 4'd0);
    chk("rst_irq", {3'b0, irq}, 4'd0);
    n_reset = 1'b1;
    step(4'd4, 1'b1);
    chk("rst_release_pending", {3'b0, pending}, 4'd0);

    // Reset asserted between edges has no effect until an edge
    cmp_din = 4'd2; cmp_wr = 1'b1; step(4'd5, 1'b0);
    n_reset = 1'b0;
    #3;
    chk("midcycle_rst_pending", {3'b0, pending}, 4'd1);
    n_reset = 1'b1;

    // Edge-aligned: write 5 while counting up from 7
    cmp_din = 4'd5; cmp_wr = 1'b1; step(4'd7, 1'b1);
    for (int q = 8; q <= 15; q++) step(4'(q), 1'b1);
    chk("edge_before_min", cmp_active, 4'd0);
    step(4'd0, 1'b1);
    chk("edge_after_min", cmp_active, 4'd5);
    for (int p = 0; p < 2; p++) begin
      for (int q = (p == 0) ? 1 : 0; q <= 15; q++) begin
        step(4'(q), 1'b1);
        if (q == 4) chk("edge_pwm_q4", {3'b0, pwm_out}, 4'd1);
        if (q == 5) chk("edge_match_q5", {3'b0, cmp_match}, 4'd1);
        if (q == 5) chk("edge_pwm_q5", {3'b0, pwm_out}, 4'd0);
      end
    end

    // Centre-aligned, bouncing counter; write 3 while counting up
    upd_mode = 1'b1;
    step(4'd0, 1'b1);
    cmp_din = 4'd3; cmp_wr = 1'b1; step(4'd1, 1'b1);
    for (int q = 2; q <= 15; q++) step(4'(q), 1'b1);
    chk("centre_after_max", cmp_active, 4'd3);
    for (int q = 14; q >= 0; q--) step(4'(q), 1'b1);
    out_pol = 1'b1;
    for (int q = 1; q <= 15; q++) begin
      step(4'(q), 1'b1);
      if (q == 2) chk("centre_inv_pwm_q2", {3'b0, pwm_out}, 4'd0);
    end
    for (int q = 14; q >= 0; q--) step(4'(q), 1'b1);

    // Collision of a write with the update boundary
    upd_mode = 1'b0; out_pol = 1'b0;
    cmp_din = 4'd6; cmp_wr = 1'b1; step(4'd1, 1'b1);
    for (int q = 2; q <= 15; q++) step(4'(q), 1'b1);
    cmp_din = 4'd10; cmp_wr = 1'b1; step(4'd0, 1'b1);
    chk("coll_active", cmp_active, 4'd6);
    chk("coll_pending", {3'b0, pending}, 4'd1);
    for (int q = 1; q <= 15; q++) step(4'(q), 1'b1);
    step(4'd0, 1'b1);
    chk("coll_next_active", cmp_active, 4'd10);
    chk("coll_next_pending", {3'b0, pending}, 4'd0);

    // Interrupt / overrun sequence (active = 10)
    irq_ack = 1'b1; step(4'd2, 1'b1);
    chk("irq_cleared", {3'b0, irq}, 4'd0);
    step(4'd10, 1'b1);
    chk("irq_first", {3'b0, irq}, 4'd1);
    chk("ovr_first", {3'b0, ovr}, 4'd0);
    step(4'd11, 1'b1);
    step(4'd10, 1'b1);
    chk("ovr_second", {3'b0, ovr}, 4'd1);
    irq_ack = 1'b1; step(4'd10, 1'b1);
    chk("irq_ack_collide", {3'b0, irq}, 4'd1);
    chk("ovr_ack_collide", {3'b0, ovr}, 4'd1);
    irq_ack = 1'b1; step(4'd11, 1'b1);
    chk("irq_lone_ack", {3'b0, irq}, 4'd0);
    chk("ovr_lone_ack", {3'b0, ovr}, 4'd0);

    // Boundary: compare value 0 gives no PWM high
    cmp_din = 4'd0; cmp_wr = 1'b1; step(4'd12, 1'b1);
    for (int q = 13; q <= 15; q++) step(4'(q), 1'b1);
    step(4'd0, 1'b1);
    for (int q = 1; q <= 15; q++) begin
      step(4'(q), 1'b1);
      chk("zero_pwm", {3'b0, pwm_out}, 4'd0);
    end

    // Boundary: compare value 15
    cmp_din = 4'd15; cmp_wr = 1'b1; step(4'd0, 1'b1);
    for (int q = 1; q <= 15; q++) step(4'(q), 1'b1);
    step(4'd0, 1'b1);
    chk("max_active", cmp_active, 4'd15);
    for (int q = 1; q <= 14; q++) begin
      if (q == 14) irq_ack = 1'b1;
      step(4'(q), 1'b1);
      chk("max_pwm_high", {3'b0, pwm_out}, 4'd1);
    end

    // Paused counter sitting on the compare value
    for (int i = 0; i < 5; i++) begin
      step(4'd15, 1'b0);
      chk("pause_match", {3'b0, cmp_match}, 4'd0);
      chk("pause_irq", {3'b0, irq}, 4'd0);
    end
    step(4'd15, 1'b1);
    chk("max_pwm_q15", {3'b0, pwm_out}, 4'd0);
    chk("resume_match", {3'b0, cmp_match}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
